// File: rtl/bus_step_sequencer.sv
// +--------------------------------------------------------------------------+
// | bus_step_sequencer                                                       |
// | Fetch/execute control-step sequencer for the shared 32-bit datapath bus. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module bus_step_sequencer #(
  parameter int         MEM_WAIT_MAX = 15,
  parameter logic [4:0] IDLE_SEL     = 5'd31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        mem_ready,
  input  logic [4:0]  ir_opcode,
  input  logic [3:0]  ir_ra,
  input  logic [3:0]  ir_rb,
  input  logic [3:0]  ir_rc,
  output logic [4:0]  bus_select,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mem_read,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic [15:0] r_in,
  output logic [3:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault
);

  localparam int         c_WW        = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(MEM_WAIT_MAX);
  localparam logic [4:0] c_SEL_ZHI   = 5'd18;
  localparam logic [4:0] c_SEL_ZLO   = 5'd19;
  localparam logic [4:0] c_SEL_PC    = 5'd20;
  localparam logic [4:0] c_SEL_MDR   = 5'd21;
  localparam logic [4:0] c_SEL_CSIGN = 5'd23;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  state_t          r_state;
  logic [c_WW-1:0] r_wait;
  logic            r_stop_seen;
  logic [1:0]      r_fault;
  logic [4:0]      r_sel;
  logic            r_pc_in, r_inc_pc, r_mar_in, r_mem_read, r_ir_in;
  logic            r_z_in, r_hi_in, r_lo_in, r_busy, r_done;
  logic [15:0]     r_rin;
  logic [3:0]      r_alu_op;

  state_t          w_next;
  state_t          w_boundary;
  logic [c_WW-1:0] w_wait;
  logic [1:0]      w_fault;
  logic            w_legal, w_muldiv, w_stop_any, w_stop_seen, w_in_t3;
  logic [4:0]      w_sel;
  logic            w_pc_in, w_inc_pc, w_mar_in, w_mem_read, w_ir_in;
  logic            w_z_in, w_hi_in, w_lo_in, w_busy, w_done;
  logic [15:0]     w_rin;
  logic [3:0]      w_alu_op;

  // Next-state, wait counter, fault and stop-latch logic.
  always_comb begin
    w_legal    = (ir_opcode < 5'd15);
    w_muldiv   = (ir_opcode == 5'd11) || (ir_opcode == 5'd12);
    w_stop_any = r_stop_seen | stop;
    if (w_stop_any)  w_boundary = S_HALT;
    else if (start)  w_boundary = S_T0;
    else             w_boundary = S_IDLE;

    w_next  = r_state;
    w_wait  = '0;
    w_fault = r_fault;
    case (r_state)
      S_IDLE: if (start) begin
        w_next  = S_T0;
        w_fault = 2'b00;
      end
      S_T0: w_next = S_T1;
      S_T1: begin
        w_wait = r_wait + 1'b1;
        // A ready arriving on the final allowed cycle still wins over the timeout.
        if (mem_ready) begin
          w_next = S_T2;
        end else if (w_wait == c_WAIT_LAST) begin
          w_next  = S_IDLE;
          w_fault = 2'b10;
        end
      end
      S_T2: w_next = S_T3;
      S_T3: if (w_legal) begin
        w_next = S_T4;
      end else begin
        w_next  = S_IDLE;
        w_fault = 2'b01;
      end
      S_T4: w_next = S_T5;
      S_T5: w_next = w_muldiv ? S_T6 : w_boundary;
      S_T6: w_next = w_boundary;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase

    if (w_next == S_T0 || r_state == S_IDLE || r_state == S_HALT) w_stop_seen = 1'b0;
    else                                                           w_stop_seen = w_stop_any;
  end

  // Output decode from the state being entered, so every strobe is a flop output.
  always_comb begin
    w_sel      = IDLE_SEL;
    w_pc_in    = 1'b0;
    w_inc_pc   = 1'b0;
    w_mar_in   = 1'b0;
    w_mem_read = 1'b0;
    w_ir_in    = 1'b0;
    w_z_in     = 1'b0;
    w_hi_in    = 1'b0;
    w_lo_in    = 1'b0;
    w_done     = 1'b0;
    w_rin      = '0;
    w_alu_op   = '0;
    w_busy     = (w_next != S_IDLE) && (w_next != S_HALT);
    case (w_next)
      S_T0: begin
        w_sel    = c_SEL_PC;
        w_mar_in = 1'b1;
        w_inc_pc = 1'b1;
        w_z_in   = 1'b1;
      end
      S_T1: begin
        w_sel      = c_SEL_ZLO;
        w_mem_read = 1'b1;
        w_pc_in    = (r_state != S_T1);
      end
      S_T2: begin
        w_sel   = c_SEL_MDR;
        w_ir_in = 1'b1;
      end
      S_T4: begin
        w_z_in   = 1'b1;
        w_alu_op = ir_opcode[3:0];
        if (ir_opcode >= 5'd8 && ir_opcode <= 5'd10)        w_sel = c_SEL_CSIGN;
        else if (ir_opcode == 5'd13 || ir_opcode == 5'd14)  w_sel = {1'b0, ir_rb};
        else                                                w_sel = {1'b0, ir_rc};
      end
      S_T5: begin
        w_sel = c_SEL_ZLO;
        if (w_muldiv) begin
          w_lo_in = 1'b1;
        end else begin
          w_rin[ir_ra] = 1'b1;
          w_done       = 1'b1;
        end
      end
      S_T6: begin
        w_sel   = c_SEL_ZHI;
        w_hi_in = 1'b1;
        w_done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_stop_seen <= 1'b0;
      r_fault     <= 2'b00;
      r_sel       <= IDLE_SEL;
      r_pc_in     <= 1'b0;
      r_inc_pc    <= 1'b0;
      r_mar_in    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_ir_in     <= 1'b0;
      r_z_in      <= 1'b0;
      r_hi_in     <= 1'b0;
      r_lo_in     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rin       <= '0;
      r_alu_op    <= '0;
    end else begin
      r_state     <= w_next;
      r_wait      <= w_wait;
      r_stop_seen <= w_stop_seen;
      r_fault     <= w_fault;
      r_sel       <= w_sel;
      r_pc_in     <= w_pc_in;
      r_inc_pc    <= w_inc_pc;
      r_mar_in    <= w_mar_in;
      r_mem_read  <= w_mem_read;
      r_ir_in     <= w_ir_in;
      r_z_in      <= w_z_in;
      r_hi_in     <= w_hi_in;
      r_lo_in     <= w_lo_in;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_rin       <= w_rin;
      r_alu_op    <= w_alu_op;
    end
  end

  // IR fields only become valid in T3, so the T3 source/y_in and the MDR strobe
  // are the registered step qualified by the live inputs.
  assign w_in_t3    = (r_state == S_T3);
  assign bus_select = w_in_t3 ? (w_legal ? {1'b0, ir_rb} : IDLE_SEL) : r_sel;
  assign y_in       = w_in_t3 & w_legal;
  assign mdr_in     = r_mem_read & mem_ready;

  assign pc_in    = r_pc_in;
  assign inc_pc   = r_inc_pc;
  assign mar_in   = r_mar_in;
  assign mem_read = r_mem_read;
  assign ir_in    = r_ir_in;
  assign z_in     = r_z_in;
  assign hi_in    = r_hi_in;
  assign lo_in    = r_lo_in;
  assign r_in     = r_rin;
  assign alu_op   = r_alu_op;
  assign busy     = r_busy;
  assign done     = r_done;
  assign fault    = r_fault;

endmodule

`default_nettype wire
